mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle MIPS control unit. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. Every cycle it drives the datapath muxes, the write enables and the 3-bit ALU control code. It reads the ALU `zero` flag back to resolve `beq`, and it replaces the single-cycle combinational decoder in the multicycle build.

## Interface
Parameters:
- None. The opcode and funct encodings are fixed MIPS values, listed under Operation.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `opcode` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `zero` in 1: ALU zero flag, the same cycle's combinational result.
- `ir_write` out 1: load the instruction register.
- `mem_write` out 1: memory write enable.
- `reg_write` out 1: register file write enable.
- `i_or_d` out 1: memory address select (0=PC, 1=ALUOut).
- `alu_src_a` out 1: ALU operand A select (0=PC, 1=register A).
- `alu_src_b` out 2: ALU operand B select (00=register B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate <<2).
- `alu_ctrl` out 3: ALU operation code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
- `pc_src` out 2: next-PC select (00=ALU result, 01=ALUOut, 10=jump target).
- `mem_to_reg` out 1: writeback data select (0=ALUOut, 1=memory data).
- `reg_dst` out 1: destination register select (0=rt, 1=rd).
- `pc_en` out 1: PC write enable, equal to `pc_write | (branch & zero)`.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: one-cycle pulse when the instruction is unsupported.
- `state` out 4: current state, exported for debug and verification.

## Operation
States and their encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
- RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Codes 12–15 are unreachable. If one is ever reached, the next state is FETCH and all outputs are in their default values.

Default output values: every enable is 0, every select is 0, and `alu_ctrl`=010. Each state overrides only the outputs listed below.
- FETCH: `ir_write`=1, `pc_write`=1, `alu_src_b`=01, `alu_ctrl`=010.
- DECODE: `alu_src_b`=11, `alu_ctrl`=010 (computes the branch target).
- MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_ctrl`=010.
- MEMRD: `i_or_d`=1.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- MEMWR: `i_or_d`=1, `mem_write`=1.
- RTYPEEX: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` taken from the funct map.
- RTYPEWB: `reg_write`=1, `reg_dst`=1.
- ADDIWB: `reg_write`=1.
- BEQEX: `alu_src_a`=1, `alu_ctrl`=110, `pc_src`=01, `branch`=1.
- JEX: `pc_src`=10, `pc_write`=1.

Funct map (R-type `alu_ctrl`): 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.

Transitions:
- FETCH→DECODE.
- DECODE dispatches on `opcode`:
  - 100011 (lw) and 101011 (sw) → MEMADR.
  - 000000 (R-type) → RTYPEEX.
  - 000100 (beq) → BEQEX.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JEX.
- MEMADR→MEMRD for lw, MEMADR→MEMWR for sw.
- MEMRD→MEMWB.
- RTYPEEX→RTYPEWB.
- ADDIEX→ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX → FETCH.

Illegal instructions:
- An unknown opcode, or opcode 000000 with an unmapped funct, is detected in DECODE.
- That DECODE cycle pulses `illegal`=1 and `instr_done`=1, then goes to FETCH.
- No write enable is asserted; the instruction behaves as a NOP.

`instr_done`=1 in MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX, and in an illegal DECODE.

## Timing
- Reset: `rst_n`=0 forces `state`=FETCH immediately, without waiting for a clock edge. During reset, outputs take their FETCH values except that `ir_write` and `pc_en` are forced to 0. Normal fetching starts at the first rising edge after `rst_n` is released.
- Reset during an instruction abandons it. No write enable is asserted after the reset asserts.
- Outputs are combinational from `state`, except:
  - `alu_ctrl` in RTYPEEX also depends on `funct`.
  - `pc_en` in BEQEX also depends on `zero`.
  - `illegal` in DECODE also depends on `opcode` and `funct`.
- `opcode` and `funct` are sampled only in DECODE and RTYPEEX. The instruction register must hold them stable from the cycle after FETCH until the next FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- BEQEX with `zero`=0 gives `pc_en`=0. The PC keeps the PC+4 value written during FETCH.

## Test plan
- Reset mid-RTYPEEX: assert `rst_n`=0 → `state`=0 with no clock edge, and `reg_write`/`mem_write`/`pc_en` all 0. Release reset → DECODE follows after one clock.
- lw (`opcode`=100011): state sequence 0,1,2,3,4, with `reg_write`=1 and `mem_to_reg`=1 only in state 4. `instr_done` is seen in cycle 5.
- sw then addi: sw gives 0,1,2,5 with `mem_write`=1 only in state 5. addi gives 0,1,9,10 with `reg_write`=1 and `reg_dst`=0 in state 10.
- R-type sweep over funct 100000/100010/100100/100101/101010: `alu_ctrl` in state 6 is 010/110/000/001/111, and `reg_dst`=1 in state 7.
- beq: in state 8, `zero`=1 gives `pc_en`=1 and `pc_src`=01; `zero`=0 gives `pc_en`=0. The next state is 0 in both cases.
- Illegal: `opcode`=111111, or `opcode`=0 with `funct`=000000 → `illegal`=1 and `instr_done`=1 in state 1, then state 0, with no write enable asserted at any point. `j` gives 0,1,11, with `pc_src`=10 and `pc_en`=1 in state 11.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences
// fetch/decode/execute/memory/writeback and drives the datapath.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next;
    logic       r_is_sw;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;
    logic       w_op_legal;

    // State register; reset lands in FETCH without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Remember lw vs sw at decode so MEMADR need not re-read the opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_is_sw <= 1'b0;
        else if (r_state == S_DECODE) r_is_sw <= (opcode == OP_SW);
    end

    // R-type funct to ALU operation map
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = 3'b010;
        case (funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // Opcode legality, including unmapped R-type funct codes
    always_comb begin
        w_op_legal = 1'b0;
        case (opcode)
            OP_RTYPE: w_op_legal = w_funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
            default:  w_op_legal = 1'b0;
        endcase
    end

    // Next-state and Moore outputs, defaults first
    always_comb begin
        w_next     = S_FETCH;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b010;
        pc_src     = 2'b00;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b01;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (!w_op_legal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_RTYPEEX;
                        OP_BEQ:       w_next = S_BEQEX;
                        OP_ADDI:      w_next = S_ADDIEX;
                        OP_J:         w_next = S_JEX;
                        default:      w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = r_is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                i_or_d = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_ctrl  = w_funct_alu;
                w_next    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = 3'b110;
                pc_src     = 2'b01;
                w_branch   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JEX: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
                instr_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // IR and PC loads are suppressed while reset is held
    assign ir_write = w_ir_write & rst_n;
    assign pc_en    = (w_pc_write | (w_branch & zero)) & rst_n;
    assign state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl with
// hand-computed expected state sequences and outputs.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_write, mem_write, reg_write, i_or_d, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       mem_to_reg, reg_dst, pc_en, instr_done, illegal;
    logic [3:0] state;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .i_or_d     (i_or_d),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_src     (pc_src),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .pc_en      (pc_en),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rtype(input logic [5:0] fn, input logic [2:0] ac);
        opcode = 6'b000000;
        funct  = fn;
        chk("rt fetch", 32'(state), 0);
        cyc();
        chk("rt decode", 32'(state), 1);
        chk("rt no illegal", 32'(illegal), 0);
        cyc();
        chk("rt ex state", 32'(state), 6);
        chk("rt alu_ctrl", 32'(alu_ctrl), 32'(ac));
        chk("rt src_a", 32'(alu_src_a), 1);
        chk("rt src_b", 32'(alu_src_b), 0);
        cyc();
        chk("rt wb state", 32'(state), 7);
        chk("rt reg_dst", 32'(reg_dst), 1);
        chk("rt reg_write", 32'(reg_write), 1);
        chk("rt done", 32'(instr_done), 1);
        cyc();
        chk("rt back", 32'(state), 0);
    endtask

    task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        chk("il fetch rw", 32'(reg_write | mem_write), 0);
        cyc();
        chk("il decode", 32'(state), 1);
        chk("il illegal", 32'(illegal), 1);
        chk("il done", 32'(instr_done), 1);
        chk("il writes", 32'(reg_write | mem_write), 0);
        cyc();
        chk("il back", 32'(state), 0);
        chk("il clear", 32'(illegal), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b0;
        funct  = 6'b0;
        zero   = 1'b0;
        #3;
        chk("rst state", 32'(state), 0);
        chk("rst ir_write", 32'(ir_write), 0);
        chk("rst pc_en", 32'(pc_en), 0);
        chk("rst src_b", 32'(alu_src_b), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel ir_write", 32'(ir_write), 1);
        chk("rel pc_en", 32'(pc_en), 1);
        cyc();
        chk("first decode", 32'(state), 1);
        cyc();
        chk("first back", 32'(state), 0);

        // lw
        opcode = 6'b100011;
        cyc();
        chk("lw decode", 32'(state), 1);
        chk("lw dec src_b", 32'(alu_src_b), 3);
        chk("lw no illegal", 32'(illegal), 0);
        cyc();
        chk("lw memadr", 32'(state), 2);
        chk("lw src_a", 32'(alu_src_a), 1);
        chk("lw src_b", 32'(alu_src_b), 2);
        chk("lw adr rw", 32'(reg_write), 0);
        cyc();
        chk("lw memrd", 32'(state), 3);
        chk("lw i_or_d", 32'(i_or_d), 1);
        chk("lw rd rw", 32'(reg_write), 0);
        cyc();
        chk("lw memwb", 32'(state), 4);
        chk("lw reg_write", 32'(reg_write), 1);
        chk("lw mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw done", 32'(instr_done), 1);
        cyc();
        chk("lw back", 32'(state), 0);
        chk("lw fetch m2r", 32'(mem_to_reg), 0);

        // sw
        opcode = 6'b101011;
        cyc();
        chk("sw decode", 32'(state), 1);
        chk("sw dec mw", 32'(mem_write), 0);
        cyc();
        chk("sw memadr", 32'(state), 2);
        cyc();
        chk("sw memwr", 32'(state), 5);
        chk("sw mem_write", 32'(mem_write), 1);
        chk("sw i_or_d", 32'(i_or_d), 1);
        chk("sw done", 32'(instr_done), 1);
        cyc();
        chk("sw back", 32'(state), 0);
        chk("sw fetch mw", 32'(mem_write), 0);

        // addi
        opcode = 6'b001000;
        cyc();
        chk("addi decode", 32'(state), 1);
        cyc();
        chk("addi ex", 32'(state), 9);
        chk("addi src_b", 32'(alu_src_b), 2);
        cyc();
        chk("addi wb", 32'(state), 10);
        chk("addi reg_write", 32'(reg_write), 1);
        chk("addi reg_dst", 32'(reg_dst), 0);
        cyc();
        chk("addi back", 32'(state), 0);

        // R-type sweep
        run_rtype(6'b100000, 3'b010);
        run_rtype(6'b100010, 3'b110);
        run_rtype(6'b100100, 3'b000);
        run_rtype(6'b100101, 3'b001);
        run_rtype(6'b101010, 3'b111);

        // beq taken
        opcode = 6'b000100;
        cyc();
        chk("beq decode", 32'(state), 1);
        cyc();
        chk("beq ex", 32'(state), 8);
        zero = 1'b1;
        #1;
        chk("beq z1 pc_en", 32'(pc_en), 1);
        chk("beq pc_src", 32'(pc_src), 1);
        chk("beq alu_ctrl", 32'(alu_ctrl), 6);
        chk("beq done", 32'(instr_done), 1);
        cyc();
        chk("beq t back", 32'(state), 0);
        zero = 1'b0;
        // beq not taken
        cyc();
        cyc();
        chk("beq nt ex", 32'(state), 8);
        chk("beq z0 pc_en", 32'(pc_en), 0);
        cyc();
        chk("beq nt back", 32'(state), 0);

        // j
        opcode = 6'b000010;
        cyc();
        chk("j decode", 32'(state), 1);
        cyc();
        chk("j ex", 32'(state), 11);
        chk("j pc_src", 32'(pc_src), 2);
        chk("j pc_en", 32'(pc_en), 1);
        chk("j done", 32'(instr_done), 1);
        cyc();
        chk("j back", 32'(state), 0);

        // illegal instructions
        run_illegal(6'b111111, 6'b000000);
        run_illegal(6'b000000, 6'b000000);

        // reset mid-RTYPEEX
        opcode = 6'b000000;
        funct  = 6'b100000;
        cyc();
        cyc();
        chk("mr in ex", 32'(state), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr state", 32'(state), 0);
        chk("mr reg_write", 32'(reg_write), 0);
        chk("mr mem_write", 32'(mem_write), 0);
        chk("mr pc_en", 32'(pc_en), 0);
        chk("mr ir_write", 32'(ir_write), 0);
        cyc();
        chk("mr held", 32'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("mr decode", 32'(state), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
